// File: rtl/pcihellocore_botoes_entrada_pkg.sv
// pcihellocore_pio_pkg
// Shared constants for the pcihellocore input PIO slave: register map,
// edge-select codes, and the debounce counter width helper.
package pcihellocore_pio_pkg;

  // Register map seen on the 2-bit Avalon address.
  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } pio_addr_e;

  // Which debounced transition sets a capture bit.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 of the cycle
  // count is enough; never let it collapse to zero bits.
  function automatic int cnt_width(input int debounce_cycles);
    int w;
    w = $clog2(debounce_cycles);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/pcihellocore_botoes_entrada_if.sv
// pcihellocore_botoes_entrada_if
// Avalon-MM slave bus bundle shared by the pcihellocore PIO slaves.
//   address    : register select
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data
//   readdata   : zero-wait-state read data from the slave
interface pcihellocore_botoes_entrada_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pcihellocore_debounce_bit.sv
// pcihellocore_debounce_bit
// One input bit: two-flop synchroniser followed by a debouncer. The stable
// value only follows the synchronised input after it has disagreed for
// DEBOUNCE_CYCLES consecutive cycles.
//   clk        : clock
//   reset_n    : synchronous active-low reset
//   din_i      : asynchronous board input
//   stable_o   : current debounced value
//   stable_d_o : value stable_o takes at the next edge (for edge detect)
module pcihellocore_debounce_bit
  import pcihellocore_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic stable_o,
  output logic stable_d_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce next-state: any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchroniser, counter and stable flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o   = stable_q;
  assign stable_d_o = stable_d;

endmodule

// File: rtl/pcihellocore_botoes_entrada.sv
// pcihellocore_botoes_entrada
// Avalon-MM input PIO: debounced board inputs, sticky edge capture with
// write-1-to-clear, interrupt mask and level interrupt.
//   clk     : sole clock
//   reset_n : synchronous active-low reset
//   bus     : Avalon slave (0 data, 1 reserved, 2 irq mask, 3 edge capture)
//   in_port : asynchronous board inputs
//   irq     : high while any masked capture bit is set
module pcihellocore_botoes_entrada
  import pcihellocore_pio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  logic                          clk,
  input  logic                          reset_n,
  pcihellocore_botoes_entrada_if.slave  bus,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] capture_d;
  logic [31:0]      rdata;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pcihellocore_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .din_i      (in_port[i]),
      .stable_o   (stable_q[i]),
      .stable_d_o (stable_d[i])
    );
  end

  // Edges are taken from the debouncer's next value so capture lands on
  // the same clock edge as the stable change.
  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALLING: edge_hit = ~stable_d & stable_q;
      EDGE_ANY:     edge_hit = stable_d ^ stable_q;
      default:      edge_hit = stable_d & ~stable_q;
    endcase
  end

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Register write decode; a new edge overrides a simultaneous clear.
  always_comb begin
    mask_d   = mask_q;
    clr_bits = '0;
    if (wr_en) begin
      case (pio_addr_e'(bus.address))
        ADDR_MASK: mask_d   = bus.writedata[WIDTH-1:0];
        ADDR_EDGE: clr_bits = bus.writedata[WIDTH-1:0];
        default:   mask_d   = mask_q;
      endcase
    end else begin
      mask_d = mask_q;
    end
    capture_d = (capture_q & ~clr_bits) | edge_hit;
  end

  // Mask and capture registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q    <= '0;
      capture_q <= '0;
    end else begin
      mask_q    <= mask_d;
      capture_q <= capture_d;
    end
  end

  // Zero-wait read mux; chipselect is deliberately not part of it.
  always_comb begin
    rdata = 32'h0000_0000;
    case (pio_addr_e'(bus.address))
      ADDR_DATA: rdata[WIDTH-1:0] = stable_q;
      ADDR_MASK: rdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rdata[WIDTH-1:0] = capture_q;
      default:   rdata = 32'h0000_0000;
    endcase
  end

  assign bus.readdata = rdata;
  assign irq          = |(capture_q & mask_q);

  // Upper writedata bits are unused when WIDTH < 32.
  assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_pcihellocore_botoes_entrada.sv
// Testbench for pcihellocore_botoes_entrada: three instances (rising/32,
// falling/32, any/8 bits) share one input vector and one bus stimulus and
// are compared every cycle against a window-based reference model.
module tb_pcihellocore_botoes_entrada;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_port;
  logic [1:0]  tb_addr;
  logic        tb_cs;
  logic        tb_wn;
  logic [31:0] tb_wdata;
  logic [2:0]  irq_s;
  logic [31:0] rd_s [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pcihellocore_botoes_entrada_if bus0 ();
  pcihellocore_botoes_entrada_if bus1 ();
  pcihellocore_botoes_entrada_if bus2 ();

  assign bus0.address = tb_addr;  assign bus0.chipselect = tb_cs;
  assign bus0.write_n = tb_wn;    assign bus0.writedata  = tb_wdata;
  assign bus1.address = tb_addr;  assign bus1.chipselect = tb_cs;
  assign bus1.write_n = tb_wn;    assign bus1.writedata  = tb_wdata;
  assign bus2.address = tb_addr;  assign bus2.chipselect = tb_cs;
  assign bus2.write_n = tb_wn;    assign bus2.writedata  = tb_wdata;
  assign rd_s[0] = bus0.readdata;
  assign rd_s[1] = bus1.readdata;
  assign rd_s[2] = bus2.readdata;

  pcihellocore_botoes_entrada #(.WIDTH(32), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq_s[0]));
  pcihellocore_botoes_entrada #(.WIDTH(32), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq_s[1]));
  pcihellocore_botoes_entrada #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port[7:0]), .irq(irq_s[2]));

  // Reference model: a bit's stable value flips once the input seen two
  // cycles late has held the opposite value for D consecutive samples.
  logic [31:0] hist [D+2];
  logic [31:0] m_stable;
  logic [31:0] m_cap  [3];
  logic [31:0] m_mask [3];
  logic [31:0] m_w    [3];

  task automatic model_edge();
    logic [31:0] all_hi, all_lo, new_st, ed, clr;
    logic        wr;
    if (!reset_n) begin
      for (int k = 0; k < D + 2; k++) hist[k] = 32'h0;
      m_stable = 32'h0;
      for (int j = 0; j < 3; j++) begin
        m_cap[j] = 32'h0; m_mask[j] = 32'h0;
      end
    end else begin
      for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_port;
      all_hi = 32'hFFFF_FFFF;
      all_lo = 32'hFFFF_FFFF;
      for (int k = 2; k < D + 2; k++) begin
        all_hi &= hist[k];
        all_lo &= ~hist[k];
      end
      new_st = (m_stable | all_hi) & ~all_lo;
      wr = tb_cs && !tb_wn;
      for (int j = 0; j < 3; j++) begin
        if (j == 0)      ed = new_st & ~m_stable;
        else if (j == 1) ed = ~new_st & m_stable;
        else             ed = new_st ^ m_stable;
        clr = (wr && tb_addr == 2'd3) ? tb_wdata : 32'h0;
        m_cap[j] = ((m_cap[j] & ~clr) | ed) & m_w[j];
        if (wr && tb_addr == 2'd2) m_mask[j] = tb_wdata & m_w[j];
      end
      m_stable = new_st;
    end
  endtask

  task automatic check_all();
    logic [31:0] exp;
    logic        exp_irq;
    for (int j = 0; j < 3; j++) begin
      exp_irq = |(m_cap[j] & m_mask[j]);
      nvec++;
      assert (irq_s[j] === exp_irq) else begin
        nerr++;
        $error("FAIL irq%0d got %b exp %b at %0t", j, irq_s[j], exp_irq, $time);
      end
    end
    for (int a = 0; a < 4; a++) begin
      tb_addr = 2'(a);
      #1;
      for (int j = 0; j < 3; j++) begin
        case (a)
          0:       exp = m_stable & m_w[j];
          2:       exp = m_mask[j];
          3:       exp = m_cap[j];
          default: exp = 32'h0;
        endcase
        nvec++;
        assert (rd_s[j] === exp) else begin
          nerr++;
          $error("FAIL rd%0d_addr%0d got %h exp %h at %0t", j, a, rd_s[j], exp, $time);
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    tb_cs = 1'b0;
    tb_wn = 1'b1;
    check_all();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    tb_addr = a; tb_cs = 1'b1; tb_wn = 1'b0; tb_wdata = d;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int lat;
    m_w[0] = 32'hFFFF_FFFF; m_w[1] = 32'hFFFF_FFFF; m_w[2] = 32'h0000_00FF;
    for (int k = 0; k < D + 2; k++) hist[k] = 32'h0;
    m_stable = 32'h0;
    for (int j = 0; j < 3; j++) begin
      m_cap[j] = 32'h0; m_mask[j] = 32'h0;
    end
    reset_n = 1'b0; in_port = 32'h0; tb_addr = 2'd0;
    tb_cs = 1'b0; tb_wn = 1'b1; tb_wdata = 32'h0;

    // Reset state.
    steps(2);
    reset_n = 1'b1;
    steps(2);

    // Raise bit 0 and measure the read latency in cycles.
    in_port = 32'h0000_0001;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      tb_addr = 2'd0;
      #1;
      if (rd_s[0][0] === 1'b1) break;
    end
    nvec++;
    assert (lat == D + 2) else begin
      nerr++;
      $error("FAIL latency got %0d exp %0d", lat, D + 2);
    end
    steps(2);

    // Enable mask on bit 0, then a too-short pulse on bit 1.
    bus_write(2'd2, 32'h0000_0001); step();
    in_port = 32'h0000_0003; steps(3);
    in_port = 32'h0000_0001; steps(8);

    // Re-arm bit 0 edge with mask set: fall then rise.
    in_port = 32'h0000_0000; steps(8);
    in_port = 32'h0000_0001; steps(8);

    // Build capture 0x3 with mask 0x3, clear one bit at a time.
    bus_write(2'd2, 32'h0000_0003); step();
    in_port = 32'h0000_0003; steps(8);
    bus_write(2'd3, 32'h0000_0001); step();
    bus_write(2'd3, 32'h0000_0002); step();
    step();

    // Clear bit 2 on the very edge its rising edge lands: set wins.
    in_port = 32'h0000_0007;
    steps(D + 1);
    bus_write(2'd3, 32'h0000_0004); step();
    steps(2);

    // All ones then all zeros (exercises falling and any-edge instances).
    in_port = 32'hFFFF_FFFF; steps(8);
    bus_write(2'd3, 32'hFFFF_FFFF); step();
    in_port = 32'h0000_0000; steps(8);
    bus_write(2'd2, 32'hFFFF_FFFF); step();

    // Reset for one cycle in the middle of a debounce window.
    in_port = 32'h0000_0008; steps(4);
    reset_n = 1'b0; step();
    reset_n = 1'b1; steps(8);

    // Randomised phase: slow-changing inputs, glitches, writes, rare resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) in_port = $urandom;
      else if ($urandom_range(0, 5) == 0) in_port = in_port ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) bus_write(2'($urandom_range(0, 3)), $urandom);
      reset_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
